// File: rtl/i2s_tx.sv
// I2S (Philips) transmitter: one holding register feeding a frame shifter, with BCLK/LRCLK derived
// from the system clock. Optional I2S_TX_REPEAT_EN replays the last frame on underrun.
module i2s_tx #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);

  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned POS_W   = $clog2(FRAME_W);
  localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]    div_q;
  logic                bclk_q, lrclk_q, sdata_q;
  logic                full_q, full_d;
  logic                frame_start_q, underrun_q;
  logic [POS_W-1:0]    pos_q, pos_next;
  logic [FRAME_W-1:0]  shift_q, shift_d, load_frame, refill;
  logic [SLOT_W-1:0]   l_slot, r_slot;
  logic [SAMPLE_W-1:0] hold_l_q, hold_r_q;
  logic                div_wrap, fall, latch, accept;

  assign div_wrap = (div_q == DIV_W'(BCLK_DIV - 1));
  assign fall     = div_wrap & bclk_q;
  assign pos_next = (pos_q == POS_W'(FRAME_W - 1)) ? '0 : pos_q + 1'b1;
  assign latch    = fall && (pos_next == '0);
  assign accept   = valid_in && !full_q;

  // Samples are MSB-aligned in their slot; the pad bits below them are sent as zeros.
  always_comb begin
    l_slot = '0;
    r_slot = '0;
    l_slot[SLOT_W-1 -: SAMPLE_W] = hold_l_q;
    r_slot[SLOT_W-1 -: SAMPLE_W] = hold_r_q;
    load_frame = {l_slot, r_slot};
  end

`ifdef I2S_TX_REPEAT_EN
  logic [FRAME_W-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (latch && full_q) begin
      last_q <= load_frame;
    end
  end

  assign refill = last_q;
`else
  assign refill = '0;
`endif

  always_comb begin
    shift_d = shift_q;
    if (latch) begin
      shift_d = full_q ? load_frame : refill;
    end else if (fall) begin
      shift_d = {shift_q[FRAME_W-2:0], 1'b0};
    end
  end

  // An accept can only coincide with a latch when the register was already empty,
  // so the new pair survives for the following frame.
  always_comb begin
    full_d = full_q;
    if (latch) full_d = 1'b0;
    if (accept) full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b1;
      sdata_q       <= 1'b0;
      pos_q         <= POS_W'(FRAME_W - 1);
      shift_q       <= '0;
      full_q        <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_q         <= div_wrap ? '0 : div_q + 1'b1;
      frame_start_q <= latch;
      underrun_q    <= latch && !full_q;
      full_q        <= full_d;
      shift_q       <= shift_d;
      if (div_wrap) begin
        bclk_q <= ~bclk_q;
      end
      // The bit leaving the shifter here is frame bit p-1: the one-BCLK I2S delay.
      if (fall) begin
        pos_q   <= pos_next;
        lrclk_q <= (pos_next >= POS_W'(SLOT_W));
        sdata_q <= shift_q[FRAME_W-1];
      end
      if (accept) begin
        hold_l_q <= left_in;
        hold_r_q <= right_in;
      end
    end
  end

  assign ready_out   = !full_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: expected frames are queued as stimulus is issued; a monitor
// rebuilds each frame from BCLK rising-edge samples and checks it against the queue.
module tb_i2s_tx;

  localparam int unsigned SW  = 16;
  localparam int unsigned SL  = 32;
  localparam int unsigned DIV = 2;
  localparam int unsigned FRAME_CLK = 2 * SL * 2 * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [SW-1:0] left_in = '0;
  logic [SW-1:0] right_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out, bclk, lrclk, sdata, frame_start, underrun;

  always #5 clk = ~clk;

  i2s_tx #(
    .SAMPLE_W(SW),
    .SLOT_W  (SL),
    .BCLK_DIV(DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .left_in    (left_in),
    .right_in   (right_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  typedef struct packed {
    logic        und;
    logic        rdy;
    logic [63:0] frame;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          frames_done = 0;
  logic [63:0] last_model = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Underrun frames carry silence, or the last latched frame when repeat is built in.
  function automatic void push(input logic und, input logic rdy, input logic [15:0] l,
                               input logic [15:0] r);
    exp_t e;
    e.und = und;
    e.rdy = rdy;
    if (!und) begin
      e.frame    = {l, 16'h0000, r, 16'h0000};
      last_model = e.frame;
    end else begin
`ifdef I2S_TX_REPEAT_EN
      e.frame = last_model;
`else
      e.frame = '0;
`endif
    end
    q.push_back(e);
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    left_in  = l;
    right_in = r;
    valid_in = 1'b1;
    while (!ready_out && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_out never rose for pair %h/%h", l, r);
    end else begin
      @(negedge clk);
    end
  endtask

  // Monitor: bit k of a frame is sampled at the (k+2)-th BCLK rise after its frame_start,
  // the final bit at the first rise of the next frame.
  initial begin
    logic        prev_bclk = 1'b0;
    int          r = 0;
    bit          have_cur = 0, have_prev = 0, fs_seen = 0;
    int          last_fs = 0;
    exp_t        cur_e, prev_e, e;
    logic [63:0] bits = '0, lr = '0, prev_bits = '0, prev_lr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_bclk = 1'b0;
        r         = 0;
        have_cur  = 0;
        have_prev = 0;
        fs_seen   = 0;
      end else begin
        if (frame_start) begin
          if (fs_seen) chk("frame_len", 64'(cyc - last_fs), 64'(FRAME_CLK));
          else chk("first_fall_cycle", 64'(cyc), 64'(2 * DIV));
          fs_seen = 1;
          last_fs = cyc;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: frame_start with no expected frame at cyc %0d", cyc);
          end else begin
            e = q.pop_front();
            chk("underrun", 64'(underrun), 64'(e.und));
            chk("ready_at_frame_start", 64'(ready_out), 64'(e.rdy));
            if (have_cur) begin
              prev_e    = cur_e;
              prev_bits = bits;
              prev_lr   = lr;
              have_prev = 1;
            end
            cur_e    = e;
            have_cur = 1;
            r        = 0;
            bits     = '0;
            lr       = '0;
          end
        end
        if (bclk && !prev_bclk && have_cur) begin
          r++;
          if (r == 1 && have_prev) begin
            prev_bits[0] = sdata;
            chk("frame_data", prev_bits, prev_e.frame);
            chk("lrclk_pattern", prev_lr, 64'h0000_0000_FFFF_FFFF);
            have_prev = 0;
            frames_done++;
          end else if (r >= 2 && r <= 64) begin
            bits[65-r] = sdata;
          end
          if (r <= 64) lr[64-r] = lrclk;
        end
        prev_bclk = bclk;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pl[4];
    logic [15:0] pr[4];
    pl = '{16'h1234, 16'hFFFF, 16'h0001, 16'h8000};
    pr = '{16'h5678, 16'h0000, 16'h7FFE, 16'hC3A5};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd1);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);

    // Pair offered before the first frame, then two starved frames.
    left_in  = 16'hA5C3;
    right_in = 16'h8001;
    valid_in = 1'b1;
    push(1'b0, 1'b1, 16'hA5C3, 16'h8001);
    push(1'b1, 1'b1, 16'h0, 16'h0);
    push(1'b1, 1'b1, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(1);
    valid_in = 1'b0;
    chk("ready_after_accept", 64'(ready_out), 64'd0);

    // Back-to-back stream: each pair sent exactly once, in order, no underrun.
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, pl[k], pr[k]);
    push(1'b1, 1'b1, 16'h0, 16'h0);
    wait_until(4 + 2 * FRAME_CLK + 10);
    for (int k = 0; k < 4; k++) send(pl[k], pr[k]);
    valid_in = 1'b0;

    // Pair accepted on the very edge of the frame-8 latch.
    push(1'b1, 1'b0, 16'h0, 16'h0);
    push(1'b0, 1'b1, 16'hBEEF, 16'h0F0F);
    push(1'b1, 1'b1, 16'h0, 16'h0);
    wait_until(4 + 8 * FRAME_CLK - 1);
    left_in  = 16'hBEEF;
    right_in = 16'h0F0F;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;

    // Mid-frame reset around p=20 of frame 10 with a pair pending in the holding register.
    wait_until(4 + 10 * FRAME_CLK + 20 * 2 * DIV + 2);
    left_in  = 16'hDEAD;
    right_in = 16'hCAFE;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("ready_while_pending", 64'(ready_out), 64'd0);
    chk("queue_drained_before_reset", 64'(q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_bclk", 64'(bclk), 64'd0);
    chk("midrst_lrclk", 64'(lrclk), 64'd1);
    chk("midrst_sdata", 64'(sdata), 64'd0);
    chk("midrst_ready", 64'(ready_out), 64'd1);
    last_model = '0;
    push(1'b1, 1'b1, 16'h0, 16'h0);
    push(1'b1, 1'b1, 16'h0, 16'h0);
    push(1'b1, 1'b1, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(4 + 2 * FRAME_CLK + 8);
    chk("queue_drained_at_end", 64'(q.size()), 64'd0);
    chk("frames_compared", 64'(frames_done), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
